// File: rtl/blink_rate_sel.sv
// -----------------------------------------------------------------------------
// blink_rate_sel
//
// Purpose:
//   Debounces a bouncing pushbutton and uses each accepted press to step a
//   2-bit blink-rate index (0 -> 1 -> 2 -> 3 -> 0). A 26-bit prescaler emits
//   a one-cycle tick at the period selected by that index; the tick feeds a
//   downstream LED toggle stage.
//
// Parameters:
//   DB_CYCLES : cycles the synchronized button must stay stable before a
//               level change is accepted
//   PERIOD_0  : tick period in cycles for rate 0 (2 .. 2**26)
//   PERIOD_1  : tick period in cycles for rate 1 (2 .. 2**26)
//   PERIOD_2  : tick period in cycles for rate 2 (2 .. 2**26)
//   PERIOD_3  : tick period in cycles for rate 3 (2 .. 2**26)
//
// Ports:
//   clk      in   1  single clock, rising edge
//   rst      in   1  asynchronous, active-high reset
//   btn_in   in   1  raw pushbutton (asynchronous, bouncing), 1 = pressed
//   tick     out  1  one-cycle pulse at the selected rate (registered)
//   rate_sel out  2  currently selected rate index (registered)
//   press    out  1  one-cycle pulse per accepted debounced press (registered)
// -----------------------------------------------------------------------------
module blink_rate_sel #(
    parameter int DB_CYCLES = 1_000_000,
    parameter int PERIOD_0  = 50_000_000,
    parameter int PERIOD_1  = 25_000_000,
    parameter int PERIOD_2  = 12_500_000,
    parameter int PERIOD_3  = 6_250_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       tick,
    output logic [1:0] rate_sel,
    output logic       press
);

    // -------------------------------------------------------------------------
    // Local constants
    // -------------------------------------------------------------------------
    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned PS_W  = 26;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [PS_W-1:0] RELOAD_0 = PS_W'(PERIOD_0 - 1);
    localparam logic [PS_W-1:0] RELOAD_1 = PS_W'(PERIOD_1 - 1);
    localparam logic [PS_W-1:0] RELOAD_2 = PS_W'(PERIOD_2 - 1);
    localparam logic [PS_W-1:0] RELOAD_3 = PS_W'(PERIOD_3 - 1);
    localparam logic [PS_W-1:0] PS_ONE   = PS_W'(1);

    typedef enum logic [1:0] {
        LOW,
        WAIT_HIGH,
        HIGH,
        WAIT_LOW
    } db_state_t;

    // -------------------------------------------------------------------------
    // Signals
    // -------------------------------------------------------------------------
    logic [1:0]       r_sync;
    logic             w_btn_s;

    db_state_t        r_state;
    db_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] w_db_cnt_nxt;
    logic             w_press_evt;
    logic             r_press;

    logic [1:0]       r_rate;
    logic [1:0]       w_rate_after;

    logic [PS_W-1:0]  r_ps;
    logic [PS_W-1:0]  w_reload;
    logic             w_ps_zero;
    logic             r_tick;

    // -------------------------------------------------------------------------
    // Two-flop synchronizer; nothing downstream looks at btn_in directly.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], btn_in};
        end
    end

    assign w_btn_s = r_sync[1];

    // -------------------------------------------------------------------------
    // Debounce FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= LOW;
            r_db_cnt <= '0;
            r_press  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_db_cnt <= w_db_cnt_nxt;
            r_press  <= w_press_evt;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce FSM: next state, counter and press event.
    // The counter only advances while below CNT_LAST; at CNT_LAST the state
    // always leaves the wait state, so the counter can never wrap.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_db_cnt_nxt = r_db_cnt;
        w_press_evt  = 1'b0;

        case (r_state)
            LOW: begin
                if (w_btn_s) begin
                    w_state_nxt  = WAIT_HIGH;
                    w_db_cnt_nxt = '0;
                end
            end

            WAIT_HIGH: begin
                if (!w_btn_s) begin
                    w_state_nxt = LOW;
                end else if (r_db_cnt == CNT_LAST) begin
                    w_state_nxt = HIGH;
                    w_press_evt = 1'b1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + CNT_ONE;
                end
            end

            HIGH: begin
                if (!w_btn_s) begin
                    w_state_nxt  = WAIT_LOW;
                    w_db_cnt_nxt = '0;
                end
            end

            WAIT_LOW: begin
                if (w_btn_s) begin
                    w_state_nxt = HIGH;
                end else if (r_db_cnt == CNT_LAST) begin
                    w_state_nxt = LOW;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + CNT_ONE;
                end
            end

            default: begin
                w_state_nxt  = LOW;
                w_db_cnt_nxt = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Rate index. It steps on the registered press pulse, so the new index
    // shows up on rate_sel the cycle after press.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rate <= '0;
        end else if (r_press) begin
            r_rate <= r_rate + 2'd1;
        end
    end

    // The prescaler must already run at the new period from the press cycle
    // onward, so it looks ahead at the index the press is about to produce.
    assign w_rate_after = w_press_evt ? (r_rate + 2'd1) : r_rate;

    always_comb begin
        w_reload = RELOAD_0;
        case (w_rate_after)
            2'd0:    w_reload = RELOAD_0;
            2'd1:    w_reload = RELOAD_1;
            2'd2:    w_reload = RELOAD_2;
            2'd3:    w_reload = RELOAD_3;
            default: w_reload = RELOAD_0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Prescaler: 26-bit down-counter. Reaching zero produces the tick and a
    // reload; a press reloads as well so the new rate takes effect at once.
    // A press landing on the zero cycle still ticks.
    // -------------------------------------------------------------------------
    assign w_ps_zero = (r_ps == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ps   <= RELOAD_0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_ps_zero;
            if (w_press_evt || w_ps_zero) begin
                r_ps <= w_reload;
            end else begin
                r_ps <= r_ps - PS_ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all straight from registers)
    // -------------------------------------------------------------------------
    assign tick     = r_tick;
    assign press    = r_press;
    assign rate_sel = r_rate;

endmodule

// File: tb/tb_blink_rate_sel.sv
// -----------------------------------------------------------------------------
// tb_blink_rate_sel
//
// Directed scenarios followed by randomized button activity, all compared
// cycle by cycle against a behavioural model of the rules:
//   - the button is seen two edges late;
//   - a level is accepted once the seen value has differed from the current
//     accepted level on DB+1 consecutive edges; acceptance of a high level
//     is a press;
//   - ticks are scheduled as absolute cycle numbers: a press schedules the
//     next tick PERIOD_new cycles out, otherwise a tick schedules the next
//     one PERIOD_cur cycles out;
//   - rate_sel moves one cycle after press.
// -----------------------------------------------------------------------------
module tb_blink_rate_sel;

    localparam int DB = 4;
    localparam int PER [4] = '{8, 6, 4, 2};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_in = 1'b0;
    logic       tick;
    logic [1:0] rate_sel;
    logic       press;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic m_s1, m_s2;
    logic m_level;
    int   m_run;
    int   m_rate;
    logic m_pend;
    int   m_cycle;
    int   m_next_tick;
    logic m_tick;
    logic m_press;

    blink_rate_sel #(
        .DB_CYCLES (DB),
        .PERIOD_0  (8),
        .PERIOD_1  (6),
        .PERIOD_2  (4),
        .PERIOD_3  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .tick     (tick),
        .rate_sel (rate_sel),
        .press    (press)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of run, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, m_cycle);
        end
    endtask

    task automatic check_all();
        check("tick",     {1'b0, tick},  {1'b0, m_tick});
        check("press",    {1'b0, press}, {1'b0, m_press});
        check("rate_sel", rate_sel,      2'(m_rate));
    endtask

    task automatic model_reset();
        m_s1 = 1'b0;
        m_s2 = 1'b0;
        m_level = 1'b0;
        m_run = 0;
        m_rate = 0;
        m_pend = 1'b0;
        m_cycle = 0;
        m_next_tick = PER[0];
        m_tick = 1'b0;
        m_press = 1'b0;
    endtask

    task automatic model_edge(input logic b);
        logic seen;
        seen = m_s2;
        m_press = 1'b0;
        if (seen != m_level) begin
            m_run++;
            if (m_run == DB + 1) begin
                m_level = seen;
                m_run = 0;
                m_press = seen;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = b;

        m_cycle++;
        if (m_pend) m_rate = (m_rate + 1) % 4;
        m_pend = m_press;

        m_tick = (m_cycle == m_next_tick);
        if (m_press)
            m_next_tick = m_cycle + PER[(m_rate + 1) % 4];
        else if (m_tick)
            m_next_tick = m_cycle + PER[m_rate];
    endtask

    // One clock cycle: drive at the falling edge, model the rising edge,
    // compare 1 time unit later, return at the next falling edge.
    task automatic cyc(input logic b);
        btn_in = b;
        @(posedge clk);
        model_edge(b);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int  d;
        bit  found;
        logic b;
        int  len;

        @(negedge clk);

        // Reset then idle: ticks at 8, 16, 24, no press, rate 0
        do_reset();
        for (int i = 0; i < 26; i++) cyc(1'b0);

        // Clean press held 20 cycles, then a clean release
        for (int i = 0; i < 20; i++) cyc(1'b1);
        for (int i = 0; i < 12; i++) cyc(1'b0);

        // Bounce 1,0,1,0 then stable high, then release
        cyc(1'b1); cyc(1'b0); cyc(1'b1); cyc(1'b0);
        for (int i = 0; i < 12; i++) cyc(1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b0);

        // Two more presses to reach rate 3, watch the fast tick, then wrap
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 10; i++) cyc(1'b1);
            for (int i = 0; i < 12; i++) cyc(1'b0);
        end
        for (int i = 0; i < 10; i++) cyc(1'b1);
        for (int i = 0; i < 26; i++) cyc(1'b0);

        // Press timed onto a prescaler-zero cycle
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            d = m_cycle + DB + 3 - m_next_tick;
            if (d >= 0 && (d % PER[m_rate]) == 0) found = 1'b1;
            else cyc(1'b0);
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL coincide_align: observed no aligned slot, expected one within 64 cycles");
        end
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1);
            if (m_press) check("coincide_tick", {1'b0, tick}, 2'b01);
        end
        for (int i = 0; i < 20; i++) cyc(1'b0);

        // Reset during WAIT_HIGH at debounce count 2
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1);
        btn_in = 1'b0;
        do_reset();
        for (int i = 0; i < 12; i++) cyc(1'b0);

        // Randomized button activity with occasional resets
        for (int k = 0; k < 60; k++) begin
            b   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 12);
            if ($urandom_range(0, 19) == 0) begin
                btn_in = 1'b0;
                do_reset();
            end
            for (int j = 0; j < len; j++) cyc(b);
        end
        for (int i = 0; i < 20; i++) cyc(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/blink_rate_sel.md
BLINK_RATE_SEL -- requirements
Module: blink_rate_sel

Interface
REQ-001 The block SHALL take parameter DB_CYCLES, default 1_000_000, as the number of cycles the synchronized button must stay stable before a level change is accepted (20 ms at 50 MHz).
REQ-002 The block SHALL take parameter PERIOD_0, default 50_000_000, as the tick period in cycles for rate 0.
REQ-003 The block SHALL take parameter PERIOD_1, default 25_000_000, as the tick period in cycles for rate 1.
REQ-004 The block SHALL take parameter PERIOD_2, default 12_500_000, as the tick period in cycles for rate 2.
REQ-005 The block SHALL take parameter PERIOD_3, default 6_250_000, as the tick period in cycles for rate 3.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 The block SHALL have port btn_in, input, 1 bit: the raw pushbutton, asynchronous to clk and bouncing; 1 means pressed.
REQ-009 The block SHALL have port tick, output, 1 bit: a one-cycle pulse at the selected rate, consumed by the downstream LED toggle stage.
REQ-010 The block SHALL have port rate_sel, output, 2 bits: the currently selected rate index.
REQ-011 The block SHALL have port press, output, 1 bit: a one-cycle pulse marking each accepted debounced press.

Function
REQ-012 btn_in SHALL pass through a 2-flop synchronizer; all logic downstream of it SHALL use only the synchronized value (btn_s).
REQ-013 The debounce FSM SHALL have exactly four states: LOW, WAIT_HIGH, HIGH and WAIT_LOW.
REQ-014 In LOW, btn_s=1 SHALL move the FSM to WAIT_HIGH and clear the debounce counter.
REQ-015 In WAIT_HIGH, btn_s=0 SHALL return the FSM to LOW.
REQ-016 In WAIT_HIGH, a debounce counter value of DB_CYCLES-1 with btn_s=1 SHALL move the FSM to HIGH and assert press for exactly one cycle; in all other cases the counter SHALL increment.
REQ-017 In HIGH, btn_s=0 SHALL move the FSM to WAIT_LOW and clear the debounce counter.
REQ-018 In WAIT_LOW, btn_s=1 SHALL return the FSM to HIGH.
REQ-019 In WAIT_LOW, the counter reaching DB_CYCLES-1 with btn_s=0 SHALL move the FSM to LOW; release SHALL NOT generate a pulse.
REQ-020 The debounce counter SHALL be ceil(log2(DB_CYCLES)) bits wide and SHALL never wrap.
REQ-021 press SHALL assert 2+DB_CYCLES cycles after the first clk edge that samples btn_in=1, provided btn_in stays stable throughout.
REQ-022 Each press pulse SHALL increment rate_sel modulo 4, wrapping 3 to 0.
REQ-023 The new rate_sel value SHALL be visible on the cycle after press.
REQ-024 The prescaler SHALL be a 26-bit down-counter; tick SHALL be asserted for exactly one cycle when it equals 0.
REQ-025 In the cycle that tick is asserted, the prescaler SHALL reload to PERIOD_sel-1, where PERIOD_sel is the period selected by the rate index in effect after that cycle's press update.
REQ-026 Without a press, tick SHALL therefore repeat exactly every PERIOD_sel cycles.
REQ-027 On a press cycle where the prescaler is not 0, the prescaler SHALL reload to PERIOD_new-1 with no tick; the first tick after the press SHALL occur PERIOD_new cycles after the press cycle.
REQ-028 When a press and prescaler==0 fall in the same cycle, tick SHALL still assert and the reload SHALL use PERIOD_new-1.
REQ-029 Each PERIOD_n SHALL satisfy 2 <= PERIOD_n <= 2^26; values outside this range are illegal and the behaviour is not required.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 While rst=1, the block SHALL asynchronously hold: tick=0, press=0, rate_sel=0, FSM=LOW, synchronizer flops=0, debounce counter=0, prescaler=PERIOD_0-1.
REQ-032 The first tick after rst deasserts SHALL occur on the PERIOD_0-th rising edge of clk.
REQ-033 rst asserted in mid-debounce or mid-count SHALL abort the operation; no press or tick pulse SHALL be generated by the interrupted operation.

Verification (bench parameters DB_CYCLES=4, PERIOD_0..3 = 8, 6, 4, 2)
REQ-034 Reset then idle, btn_in=0 -> tick on cycles 8, 16, 24; rate_sel=0; press never asserted.
REQ-035 Clean btn_in 0->1 held for 20 cycles -> press asserted once, 6 cycles after the first sample; rate_sel=1; ticks then repeat every 6 cycles starting 6 cycles after the press.
REQ-036 btn_in bouncing 1,0,1,0 on alternate cycles, then stable 1 -> no press during the bounce; exactly one press 6 cycles after the last 0->1 edge.
REQ-037 Four clean presses -> rate_sel steps 1, 2, 3, 0; at rate 3 ticks occur every 2 cycles; after the wrap they occur every 8 cycles.
REQ-038 Press timed to coincide with prescaler==0 -> tick asserted in that cycle; next tick PERIOD_new cycles later.
REQ-039 rst pulsed during WAIT_HIGH at debounce count 2 -> no press; all outputs at reset values; first tick 8 cycles after release.
